// File: rtl/ripple_borrow_subtractor.sv
// ripple_borrow_subtractor: registered ripple-borrow D = A - B - Bin (in: clk, rst_n, in_valid, A, B, Bin; out: D, Bout, Ovf, Zero, out_valid)
module ripple_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero,
  output logic             out_valid
);
  logic [WIDTH:0]   b;
  logic [WIDTH-1:0] d;
  assign b[0] = Bin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign d[i]   = A[i] ^ B[i] ^ b[i];
    assign b[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & b[i]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      D         <= '0;
      Bout      <= 1'b0;
      Ovf       <= 1'b0;
      Zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        D    <= d;
        Bout <= b[WIDTH];
        Ovf  <= b[WIDTH] ^ b[WIDTH-1];
        Zero <= ~|d;
      end
    end
endmodule

// File: tb/tb_ripple_borrow_subtractor.sv
// tb_ripple_borrow_subtractor: scoreboard bench for 4-bit and 16-bit subtractor instances
module tb_ripple_borrow_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        v4 = 1'b0, bin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0, d4;
  logic        bo4, ov4, z4, vo4;
  logic        v16 = 1'b0, bin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, d16;
  logic        bo16, ov16, z16, vo16;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [63:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
  } exp_t;
  exp_t q4[$];
  exp_t q16[$];
  ripple_borrow_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .A(a4), .B(b4), .Bin(bin4),
    .D(d4), .Bout(bo4), .Ovf(ov4), .Zero(z4), .out_valid(vo4)
  );
  ripple_borrow_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .A(a16), .B(b16), .Bin(bin16),
    .D(d16), .Bout(bo16), .Ovf(ov16), .Zero(z16), .out_valid(vo16)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // reference: arithmetic on wide integers, signed overflow from signed range
  function automatic exp_t model(input int w, input longint a, input longint b, input longint bin);
    exp_t e;
    longint full, sa, sb, sres;
    full   = a - b - bin;
    e.d    = 64'(full) & ((64'd1 << w) - 1);
    e.bout = (a < b + bin);
    sa     = a[w-1] ? a - (longint'(1) << w) : a;
    sb     = b[w-1] ? b - (longint'(1) << w) : b;
    sres   = sa - sb - bin;
    e.ovf  = (sres < -(longint'(1) << (w - 1))) || (sres > (longint'(1) << (w - 1)) - 1);
    e.zero = (e.d == 0);
    return e;
  endfunction
  task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    @(posedge clk);
    #1;
    a4 = a; b4 = b; bin4 = bin; v4 = 1'b1;
    q4.push_back(model(4, longint'(a), longint'(b), longint'(bin)));
  endtask
  task automatic go4x(input logic [3:0] a, input logic [3:0] b, input logic bin,
                      input logic [3:0] d, input logic bout, input logic ovf);
    exp_t e;
    @(posedge clk);
    #1;
    a4 = a; b4 = b; bin4 = bin; v4 = 1'b1;
    e.d = 64'(d); e.bout = bout; e.ovf = ovf; e.zero = (d == 4'd0);
    q4.push_back(e);
  endtask
  task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic bin);
    @(posedge clk);
    #1;
    a16 = a; b16 = b; bin16 = bin; v16 = 1'b1;
    q16.push_back(model(16, longint'(a), longint'(b), longint'(bin)));
  endtask
  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && vo4) begin
      if (q4.size() == 0) check("q4_spurious_valid", 64'(vo4), 64'd0);
      else begin
        e = q4.pop_front();
        check("d4", 64'(d4), e.d);
        check("bout4", 64'(bo4), 64'(e.bout));
        check("ovf4", 64'(ov4), 64'(e.ovf));
        check("zero4", 64'(z4), 64'(e.zero));
      end
    end
  end
  always @(negedge clk) begin : mon16
    exp_t e;
    if (rst_n && vo16) begin
      if (q16.size() == 0) check("q16_spurious_valid", 64'(vo16), 64'd0);
      else begin
        e = q16.pop_front();
        check("d16", 64'(d16), e.d);
        check("bout16", 64'(bo16), 64'(e.bout));
        check("ovf16", 64'(ov16), 64'(e.ovf));
        check("zero16", 64'(z16), 64'(e.zero));
      end
    end
  end
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_d", 64'(d4), 64'd0);
    check("rst_bout", 64'(bo4), 64'd0);
    check("rst_ovf", 64'(ov4), 64'd0);
    check("rst_zero", 64'(z4), 64'd0);
    check("rst_valid", 64'(vo4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    go4x(4'b1010, 4'b0101, 1'b0, 4'b0101, 1'b0, 1'b1);
    go4x(4'b1111, 4'b1010, 1'b1, 4'b0100, 1'b0, 1'b0);
    go4x(4'b0100, 4'b0010, 1'b1, 4'b0001, 1'b0, 1'b0);
    go4x(4'b0000, 4'b0110, 1'b0, 4'b1010, 1'b1, 1'b0);
    go4x(4'b0111, 4'b0111, 1'b0, 4'b0000, 1'b0, 1'b0);
    go4x(4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0);
    go4x(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    v4 = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      a4 = 4'(i * 5 + 3); b4 = 4'(i + 1); bin4 = i[0];
      @(negedge clk);
      check("hold_d", 64'(d4), 64'hf);
      check("hold_bout", 64'(bo4), 64'd1);
      check("hold_zero", 64'(z4), 64'd0);
      check("hold_valid", 64'(vo4), 64'd0);
      @(posedge clk);
      #1;
    end
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          go4(4'(a), 4'(b), c[0]);
    @(posedge clk);
    #1;
    v4 = 1'b0;
    for (int i = 0; i < 1000; i++)
      go16(16'($urandom), 16'($urandom), 1'($urandom));
    go16(16'h0000, 16'h0000, 1'b1);
    go16(16'h8000, 16'h0001, 1'b0);
    go16(16'h7fff, 16'hffff, 1'b0);
    @(posedge clk);
    #1;
    v16 = 1'b0;
    repeat (3) @(posedge clk);
    check("q4_drained", 64'(q4.size()), 64'd0);
    check("q16_drained", 64'(q16.size()), 64'd0);
    go4(4'd3, 4'd1, 1'b0);
    @(posedge clk);
    #1;
    a4 = 4'd9; b4 = 4'd2; bin4 = 1'b0; v4 = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_d", 64'(d4), 64'd0);
    check("async_rst_bout", 64'(bo4), 64'd0);
    check("async_rst_ovf", 64'(ov4), 64'd0);
    check("async_rst_zero", 64'(z4), 64'd0);
    check("async_rst_valid", 64'(vo4), 64'd0);
    @(posedge clk);
    #1;
    check("mid_rst_valid", 64'(vo4), 64'd0);
    v4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_discard", 64'(vo4), 64'd0);
      check("mid_rst_d", 64'(d4), 64'd0);
    end
    check("q4_final", 64'(q4.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ripple_borrow_subtractor.md
Name: ripple_borrow_subtractor

Overview:
- Parameterised WIDTH-bit binary subtractor computing D = A - B - Bin.
- Built as a chain of 1-bit full-subtractor cells; the borrow ripples from LSB to MSB.
- Result and flags are registered in a single output stage, giving one-cycle latency.
- Used as a generic arithmetic leaf in datapaths; the default is a 4-bit instance.

Parameters:
- WIDTH, 4, operand/result width in bits (legal range 1 to 64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies A/B/Bin; operands are captured on clk rising edge when high.
- A  input  WIDTH  minuend, unsigned (also treated as two's complement for Ovf).
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in, weight 1 at LSB.
- D  output  WIDTH  registered difference, low WIDTH bits of A - B - Bin.
- Bout  output  1  registered borrow-out of MSB cell; 1 iff A < B + Bin (unsigned).
- Ovf  output  1  registered signed overflow = borrow into MSB XOR borrow out of MSB.
- Zero  output  1  registered, 1 iff D == 0.
- out_valid  output  1  high for one cycle per accepted operand set.

Behaviour:
- Reset:
  - While rst_n is low: D = 0, Bout = 0, Ovf = 0, Zero = 0, out_valid = 0.
  - Reset takes effect asynchronously.
  - Release is sampled on the next clk rising edge.
- Per-bit cell i, with b[0] = Bin:
  - d[i] = A[i] ^ B[i] ^ b[i]
  - b[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & b[i])
- Chain outputs:
  - Combinational borrow-out = b[WIDTH].
  - Signed overflow = b[WIDTH-1] ^ b[WIDTH].
  - The cells form a combinational ripple chain. No carry-lookahead; the structure is intentionally ripple.
- Registering:
  - On each rising clk edge with in_valid = 1: D, Bout, Ovf and Zero load the chain results, and out_valid <= 1.
  - On each rising clk edge with in_valid = 0: D, Bout, Ovf and Zero hold their previous values, and out_valid <= 0.
  - Latency is exactly 1 cycle. Throughput is one operation per cycle; back-to-back in_valid is supported.
- Arithmetic rules:
  - Result wraps modulo 2^WIDTH.
  - {Bout, D} equals the (WIDTH+1)-bit two's complement of A - B - Bin.
- Boundary cases:
  - A = B, Bin = 0 -> D = 0, Zero = 1, Bout = 0.
  - A = 0, B = 0, Bin = 1 -> D = all ones, Bout = 1.
  - A = all ones, B = 0, Bin = 0 -> D = all ones, Bout = 0.
- Reset mid-operation: an operand set presented in the same cycle that rst_n falls is discarded, and out_valid stays 0.
- No X-propagation from inputs while in_valid = 0.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle -> D = 0, Bout = 0, Ovf = 0, Zero = 0 and out_valid = 0 immediately, without waiting for clk.
- Directed vectors, WIDTH = 4, in_valid = 1, back-to-back, each checked one cycle later:
  - A = 1010, B = 0101, Bin = 0 -> D = 0101, Bout = 0, Ovf = 1 (-6 - 5).
  - A = 1111, B = 1010, Bin = 1 -> D = 0100, Bout = 0.
  - A = 0100, B = 0010, Bin = 1 -> D = 0001, Bout = 0.
  - A = 0000, B = 0110, Bin = 0 -> D = 1010, Bout = 1, Ovf = 0.
- Zero/edge cases:
  - A = 0111, B = 0111, Bin = 0 -> D = 0000, Zero = 1, Bout = 0.
  - A = 0000, B = 0000, Bin = 1 -> D = 1111, Bout = 1.
- Hold: drive in_valid = 0 with changing A/B -> D/flags unchanged, and out_valid = 0 from the next cycle.
- Exhaustive: WIDTH = 4, all 512 combinations of A, B, Bin against reference model {Bout, D} = A - B - Bin, plus 1000 random vectors at WIDTH = 16.
